ps2_scan_decoder: RTL

- Parametrised successor to the keyboard controller; sits between the ps2_keyboard byte receiver and downstream consumers (display, terminal).
- Consumes raw scan-code bytes and decodes E0 (extended) and F0 (break) prefixes into complete key events.
- Optionally suppresses typematic auto-repeat, and queues events in a FIFO with a valid/ready handshake.
- Maintains press counter, held-key status and sticky error flags.

---
 rtl/ps2_scan_decoder_if.sv | 27 ++
 rtl/ps2_scan_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder_if.sv
// Byte-in / event-out bus of the scan-code decoder.
//   rx_data, rx_ready, rx_overflow : byte stream from ps2_keyboard
//   rx_nextdata_n                  : active-low pop strobe back to ps2_keyboard
//   ev_valid, ev_ready             : event queue handshake
//   ev_code, ev_ext, ev_break      : head event fields
// master is the decoder's view; slave is the surrounding system's view.
interface ps2_scan_decoder_if;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_overflow;
   logic       rx_nextdata_n;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;

   modport master (
      input  rx_data, rx_ready, rx_overflow, ev_ready,
      output rx_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
   );

   modport slave (
      output rx_data, rx_ready, rx_overflow, ev_ready,
      input  rx_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
   );
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: turns raw bytes into key events by folding the
// E0 (extended) and F0 (break) prefixes, optionally drops typematic repeats,
// and queues events in a FIFO.
//   clk, rst     : clock, synchronous active-low reset
//   bus          : byte input, pop strobe and event handshake (master modport)
//   key_held     : a make is outstanding
//   held_code    : {ext,code} of the last accepted make
//   press_count  : accepted makes, wrapping
//   drop_count   : events lost to a full queue, saturating
//   err          : sticky error (rx_overflow or 00/FF byte)
//   clr_err      : clears err and drop_count, wins over a same-cycle set
module ps2_scan_decoder #(
   parameter int FIFO_DEPTH      = 8,
   parameter int CNT_W           = 8,
   parameter bit SUPPRESS_REPEAT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   ps2_scan_decoder_if.master   bus,
   output logic                 key_held,
   output logic [8:0]           held_code,
   output logic [CNT_W-1:0]     press_count,
   output logic [CNT_W-1:0]     drop_count,
   output logic                 err,
   input  logic                 clr_err
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

   state_t           state_q, state_d;
   logic             rx_nextdata_n_q, rx_nextdata_n_d;
   logic             key_held_q, key_held_d;
   logic [8:0]       held_code_q, held_code_d;
   logic [CNT_W-1:0] press_count_q, press_count_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;
   logic             err_q, err_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [9:0]       mem_q [FIFO_DEPTH];
   logic [9:0]       mem_d [FIFO_DEPTH];

   logic accept, ev_gen, ev_is_ext, ev_is_brk, bad_byte;
   logic repeat_hit, push_req, pop, empty, full;

   always_comb begin
      state_d         = state_q;
      key_held_d      = key_held_q;
      held_code_d     = held_code_q;
      press_count_d   = press_count_q;
      drop_count_d    = drop_count_q;
      err_d           = err_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      mem_d           = mem_q;
      ev_gen          = 1'b0;
      ev_is_ext       = 1'b0;
      ev_is_brk       = 1'b0;
      bad_byte        = 1'b0;
      push_req        = 1'b0;

      // A byte is taken only while the strobe is idle, so the strobe is a
      // single-cycle low pulse and bytes arrive at most every other cycle.
      accept          = bus.rx_ready && rx_nextdata_n_q;
      rx_nextdata_n_d = !accept;

      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop   = !empty && bus.ev_ready;

      if (accept) begin
         if (bus.rx_data == 8'hE0) begin
            state_d = S_E0;
         end else if (bus.rx_data == 8'hF0) begin
            case (state_q)
               S_IDLE:  state_d = S_F0;
               S_E0:    state_d = S_E0F0;
               default: state_d = state_q;
            endcase
         end else if (bus.rx_data == 8'h00 || bus.rx_data == 8'hFF) begin
            bad_byte = 1'b1;
            state_d  = S_IDLE;
         end else begin
            ev_gen    = 1'b1;
            ev_is_ext = (state_q == S_E0) || (state_q == S_E0F0);
            ev_is_brk = (state_q == S_F0) || (state_q == S_E0F0);
            state_d   = S_IDLE;
         end
      end

      repeat_hit = SUPPRESS_REPEAT && key_held_q &&
                   ({ev_is_ext, bus.rx_data} == held_code_q);

      if (ev_gen && !ev_is_brk) begin
         if (!repeat_hit) begin
            push_req      = 1'b1;
            key_held_d    = 1'b1;
            held_code_d   = {ev_is_ext, bus.rx_data};
            press_count_d = press_count_q + CNT_W'(1);
         end
      end else if (ev_gen) begin
         push_req = 1'b1;
         if ({ev_is_ext, bus.rx_data} == held_code_q) key_held_d = 1'b0;
      end

      if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);

      // A pop in the same cycle frees the slot, so a full queue still accepts.
      if (push_req) begin
         if (!full || pop) begin
            mem_d[wr_ptr_q[AW-1:0]] = {ev_is_ext, ev_is_brk, bus.rx_data};
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         end else if (drop_count_q != '1) begin
            drop_count_d = drop_count_q + CNT_W'(1);
         end
      end

      if (clr_err) begin
         err_d        = 1'b0;
         drop_count_d = '0;
      end else if (bus.rx_overflow || bad_byte) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         rx_nextdata_n_q <= 1'b1;
         key_held_q      <= 1'b0;
         held_code_q     <= '0;
         press_count_q   <= '0;
         drop_count_q    <= '0;
         err_q           <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
      end else begin
         state_q         <= state_d;
         rx_nextdata_n_q <= rx_nextdata_n_d;
         key_held_q      <= key_held_d;
         held_code_q     <= held_code_d;
         press_count_q   <= press_count_d;
         drop_count_q    <= drop_count_d;
         err_q           <= err_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.rx_nextdata_n = rx_nextdata_n_q;
   assign bus.ev_valid      = !empty;
   assign bus.ev_code       = mem_q[rd_ptr_q[AW-1:0]][7:0];
   assign bus.ev_break      = mem_q[rd_ptr_q[AW-1:0]][8];
   assign bus.ev_ext        = mem_q[rd_ptr_q[AW-1:0]][9];
   assign key_held          = key_held_q;
   assign held_code         = held_code_q;
   assign press_count       = press_count_q;
   assign drop_count        = drop_count_q;
   assign err               = err_q;
endmodule
